// File: rtl/level_store_ctrl.sv
// level_store_ctrl
// ----------------
// Saves and restores a per-player level for the game RAM. After reset it
// zeroes one level slot per player. When game_state moves into GS_SAVE, the
// player's level is incremented and written back. When game_state moves into
// GS_LOAD, the player's slot is read into cur_level.
//
// Optional feature: define LEVEL_SATURATE_EN to make the increment stop at
// MAX_LEVEL. When the macro is not defined, the level wraps modulo 2^LEVEL_W.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   asynchronous, active-low reset
//   user_id      in   current player ID (4 bits)
//   game_state   in   game FSM state code (8 bits)
//   data_in      in   RAM read data, valid one cycle after address_out
//   address_out  out  RAM address (registered)
//   data_out     out  RAM write data (registered)
//   r_w          out  1 = write strobe this cycle (registered)
//   cur_level    out  current player level (registered)
//   busy         out  high whenever the controller is not idle (registered)
//   user_valid   out  combinational: user_id matches a USER_ID_MAP entry
module level_store_ctrl #(
  parameter int                     NUM_USERS   = 4,
  parameter int                     LEVEL_W     = 8,
  parameter int                     ADDR_W      = 8,
  parameter int                     BASE_ADDR   = 0,
  parameter logic [NUM_USERS*4-1:0] USER_ID_MAP = {4'b0100, 4'b1101, 4'b0011, 4'b1100},
  parameter logic [LEVEL_W-1:0]     MAX_LEVEL   = {LEVEL_W{1'b1}},
  parameter logic [7:0]             GS_SAVE     = 8'h20,
  parameter logic [7:0]             GS_LOAD     = 8'h30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         user_id,
  input  logic [7:0]         game_state,
  input  logic [LEVEL_W-1:0] data_in,
  output logic [ADDR_W-1:0]  address_out,
  output logic [LEVEL_W-1:0] data_out,
  output logic               r_w,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               busy,
  output logic               user_valid
);

  localparam int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

`ifdef LEVEL_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [2:0] CLEAR   = 3'd0;
  localparam logic [2:0] CLR_END = 3'd1;
  localparam logic [2:0] IDLE    = 3'd2;
  localparam logic [2:0] SAVE    = 3'd3;
  localparam logic [2:0] LD_WAIT = 3'd4;
  localparam logic [2:0] LD_CAP  = 3'd5;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_USERS - 1);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         prev_gs_q, prev_gs_d;
  logic [ADDR_W-1:0]  address_out_q, address_out_d;
  logic [LEVEL_W-1:0] data_out_q, data_out_d;
  logic               r_w_q, r_w_d;
  logic [LEVEL_W-1:0] cur_level_q, cur_level_d;
  logic               busy_q, busy_d;

  logic               hit_s;
  logic [IDX_W-1:0]   slot_s;
  logic [ADDR_W-1:0]  slot_addr_s;
  logic [LEVEL_W-1:0] next_level_s;
  logic               save_evt_s;
  logic               load_evt_s;

  // Slot lookup. The loop scans downward, so the lowest matching entry is the
  // one that remains.
  always_comb begin
    hit_s  = 1'b0;
    slot_s = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      hit_s  = hit_s | (USER_ID_MAP[4*i +: 4] == user_id);
      slot_s = (USER_ID_MAP[4*i +: 4] == user_id) ? IDX_W'(i) : slot_s;
    end
  end

  // Slot address, next level value, and edge-detected save/load events.
  always_comb begin
    slot_addr_s  = ADDR_W'(BASE_ADDR) + ADDR_W'(slot_s);
    // MAX_LEVEL only takes effect when SAT_EN is set.
    next_level_s = (SAT_EN && (cur_level_q >= MAX_LEVEL)) ? MAX_LEVEL
                                                          : cur_level_q + LEVEL_W'(1);
    save_evt_s   = (game_state == GS_SAVE) && (prev_gs_q != GS_SAVE) && hit_s;
    load_evt_s   = (game_state == GS_LOAD) && (prev_gs_q != GS_LOAD) && hit_s;
  end

  // Next-state and next-output logic for the controller FSM.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    prev_gs_d     = game_state;
    address_out_d = address_out_q;
    data_out_d    = data_out_q;
    r_w_d         = r_w_q;
    cur_level_d   = cur_level_q;
    case (state_q)
      CLEAR: begin
        address_out_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
        data_out_d    = '0;
        r_w_d         = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = CLR_END;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      CLR_END: begin
        r_w_d   = 1'b0;
        state_d = IDLE;
      end
      IDLE: begin
        r_w_d = 1'b0;
        if (save_evt_s) begin
          cur_level_d   = next_level_s;
          data_out_d    = next_level_s;
          address_out_d = slot_addr_s;
          r_w_d         = 1'b1;
          state_d       = SAVE;
        end else if (load_evt_s) begin
          // The address is latched here, so a later change of user_id has no effect.
          address_out_d = slot_addr_s;
          r_w_d         = 1'b0;
          state_d       = LD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      SAVE: begin
        r_w_d   = 1'b0;
        state_d = IDLE;
      end
      LD_WAIT: begin
        r_w_d   = 1'b0;
        state_d = LD_CAP;
      end
      LD_CAP: begin
        r_w_d       = 1'b0;
        cur_level_d = data_in;
        state_d     = IDLE;
      end
      default: begin
        r_w_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers. Reset restarts the clear sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= CLEAR;
      idx_q         <= '0;
      prev_gs_q     <= 8'h00;
      address_out_q <= '0;
      data_out_q    <= '0;
      r_w_q         <= 1'b0;
      cur_level_q   <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      prev_gs_q     <= prev_gs_d;
      address_out_q <= address_out_d;
      data_out_q    <= data_out_d;
      r_w_q         <= r_w_d;
      cur_level_q   <= cur_level_d;
      busy_q        <= busy_d;
    end
  end

  assign address_out = address_out_q;
  assign data_out    = data_out_q;
  assign r_w         = r_w_q;
  assign cur_level   = cur_level_q;
  assign busy        = busy_q;
  assign user_valid  = hit_s;

endmodule

// File: tb/tb_level_store_ctrl.sv
// Directed testbench for level_store_ctrl with default parameters.
// A small synchronous RAM model is attached to the controller's RAM port.
module tb_level_store_ctrl;

`ifdef LEVEL_SATURATE_EN
  localparam logic [7:0] SAT_WRITE  = 8'hFF;
  localparam logic [7:0] AFTER_NEXT = 8'hFF;
`else
  localparam logic [7:0] SAT_WRITE  = 8'h00;
  localparam logic [7:0] AFTER_NEXT = 8'h01;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] user_id;
  logic [7:0] game_state;
  logic [7:0] data_in;
  logic [7:0] address_out;
  logic [7:0] data_out;
  logic       r_w;
  logic [7:0] cur_level;
  logic       busy;
  logic       user_valid;

  logic       pre_en;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem [0:255];

  int checks;
  int errors;
  int pulses;
  int busy_cnt;

  level_store_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .user_id     (user_id),
    .game_state  (game_state),
    .data_in     (data_in),
    .address_out (address_out),
    .data_out    (data_out),
    .r_w         (r_w),
    .cur_level   (cur_level),
    .busy        (busy),
    .user_valid  (user_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM. A preload from the bench overrides a write.
  always @(posedge clk) begin
    if (r_w) mem[address_out] <= data_out;
    if (pre_en) mem[pre_addr] <= pre_data;
    data_in <= mem[address_out];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr"}, 32'(address_out), 32'h0);
    chk({tag, "_data"}, 32'(data_out), 32'h0);
    chk({tag, "_rw"}, 32'(r_w), 32'h0);
    chk({tag, "_lvl"}, 32'(cur_level), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h1);
  endtask

  // Call at a negedge with reset just released.
  task automatic sweep_check(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_rw"}, 32'(r_w), 32'h1);
      chk({tag, "_addr"}, 32'(address_out), 32'(k));
      chk({tag, "_data"}, 32'(data_out), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk({tag, "_end_rw"}, 32'(r_w), 32'h0);
    chk({tag, "_end_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    user_id    = 4'h0;
    game_state = 8'h00;
    pre_en     = 1'b0;
    pre_addr   = 8'h00;
    pre_data   = 8'h00;

    // Reset state, then the clear sweep
    cyc(3);
    check_reset_values("rst");
    reset = 1'b1;
    sweep_check("sweep1");

    // Save for user 0011 (slot 1), with GS_SAVE held for 10 cycles
    user_id = 4'b0011;
    #1;
    chk("valid_0011", 32'(user_valid), 32'h1);
    game_state = 8'h20;
    @(negedge clk);
    chk("save_rw", 32'(r_w), 32'h1);
    chk("save_addr", 32'(address_out), 32'h1);
    chk("save_data", 32'(data_out), 32'h1);
    chk("save_lvl", 32'(cur_level), 32'h1);
    chk("save_busy", 32'(busy), 32'h1);
    pulses = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (r_w) pulses++;
    end
    chk("save_pulses", 32'(pulses), 32'h1);
    chk("save_mem1", 32'(mem[1]), 32'h1);

    // Load for user 1101 (slot 2), with the RAM holding 07; user_id changes mid-load
    game_state = 8'h00;
    preload(8'h02, 8'h07);
    user_id    = 4'b1101;
    game_state = 8'h30;
    @(negedge clk);
    chk("load_addr", 32'(address_out), 32'h2);
    chk("load_rw", 32'(r_w), 32'h0);
    chk("load_busy", 32'(busy), 32'h1);
    chk("load_lvl_hold", 32'(cur_level), 32'h1);
    user_id = 4'b0011;
    @(negedge clk);
    chk("load_addr_latched", 32'(address_out), 32'h2);
    chk("load_busy2", 32'(busy), 32'h1);
    @(negedge clk);
    chk("load_lvl", 32'(cur_level), 32'h7);
    chk("load_busy_end", 32'(busy), 32'h0);

    // Unknown user 1111: neither a save edge nor a load edge has any effect
    user_id    = 4'b1111;
    game_state = 8'h00;
    @(negedge clk);
    chk("valid_1111", 32'(user_valid), 32'h0);
    game_state = 8'h20;
    pulses     = 0;
    busy_cnt   = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (r_w) pulses++;
      if (busy) busy_cnt++;
    end
    game_state = 8'h00;
    @(negedge clk);
    game_state = 8'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (r_w) pulses++;
      if (busy) busy_cnt++;
    end
    chk("unk_pulses", 32'(pulses), 32'h0);
    chk("unk_busy", 32'(busy_cnt), 32'h0);
    chk("unk_lvl", 32'(cur_level), 32'h7);
    chk("unk_addr", 32'(address_out), 32'h2);

    // Load FF into user 0100 (slot 3), then save: saturate or wrap
    game_state = 8'h00;
    preload(8'h03, 8'hFF);
    user_id    = 4'b0100;
    game_state = 8'h30;
    cyc(3);
    chk("sat_load_lvl", 32'(cur_level), 32'hFF);
    game_state = 8'h00;
    @(negedge clk);
    game_state = 8'h20;
    @(negedge clk);
    chk("sat_rw", 32'(r_w), 32'h1);
    chk("sat_addr", 32'(address_out), 32'h3);
    chk("sat_data", 32'(data_out), 32'(SAT_WRITE));
    chk("sat_lvl", 32'(cur_level), 32'(SAT_WRITE));

    // Save edge with a load edge on the very next cycle: the load is dropped
    game_state = 8'h00;
    @(negedge clk);
    user_id    = 4'b0011;
    game_state = 8'h20;
    @(negedge clk);
    chk("drop_save_rw", 32'(r_w), 32'h1);
    chk("drop_save_data", 32'(data_out), 32'(AFTER_NEXT));
    game_state = 8'h30;
    @(negedge clk);
    chk("drop_busy", 32'(busy), 32'h0);
    chk("drop_rw", 32'(r_w), 32'h0);
    @(negedge clk);
    chk("drop_busy_held", 32'(busy), 32'h0);
    chk("drop_addr", 32'(address_out), 32'h1);
    chk("drop_lvl", 32'(cur_level), 32'(AFTER_NEXT));

    // Reset asserted during LD_WAIT
    game_state = 8'h00;
    @(negedge clk);
    user_id    = 4'b1101;
    game_state = 8'h30;
    @(negedge clk);
    chk("ldw_busy", 32'(busy), 32'h1);
    chk("ldw_addr", 32'(address_out), 32'h2);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    game_state = 8'h00;
    @(negedge clk);
    check_reset_values("midrst_hold");
    reset = 1'b1;
    sweep_check("sweep2");
    chk("sweep2_lvl", 32'(cur_level), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_store_ctrl.md
# level_store_ctrl

Parametrised per-player level save/restore controller for the game RAM. It sits between the game FSM (`game_state`), the player-ID decoder (`user_id`) and a single-port synchronous RAM. After reset it clears one level slot per player. On the edge into the level-cleared state it increments the level and writes it back to that player's slot. On the edge into the load state it reads the slot into `cur_level`.

## Interface
Parameters:
- NUM_USERS, 4, number of player slots (1..16)
- LEVEL_W, 8, level/data width
- ADDR_W, 8, RAM address width; BASE_ADDR+NUM_USERS ≤ 2^ADDR_W
- BASE_ADDR, 0, RAM address of slot 0
- USER_ID_MAP, {4'b0100,4'b1101,4'b0011,4'b1100}, packed NUM_USERS×4 IDs; slot i matches USER_ID_MAP[4i+:4]
- MAX_LEVEL, 2^LEVEL_W−1, saturation ceiling (see Configuration)
- GS_SAVE, 8'h20, game_state code for level cleared
- GS_LOAD, 8'h30, game_state code for load level

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- user_id  in  4  current player ID
- game_state  in  8  game FSM state code
- data_in  in  LEVEL_W  RAM read data, valid one cycle after address
- address_out  out  ADDR_W  RAM address
- data_out  out  LEVEL_W  RAM write data
- r_w  out  1  1 = write strobe this cycle, 0 = read/idle
- cur_level  out  LEVEL_W  current player level
- busy  out  1  high in any state other than IDLE
- user_valid  out  1  combinational: user_id matches a USER_ID_MAP entry

## Operation
- All outputs except user_valid are registered. Reset values: address_out=0, data_out=0, r_w=0, cur_level=0, busy=1, state=CLEAR, idx=0, prev_gs=8'h00.
- Slot index = lowest i with USER_ID_MAP[4i+:4]==user_id. Address = BASE_ADDR+slot, truncated to ADDR_W.
- prev_gs <= game_state every cycle in every state.
- save_evt = (game_state==GS_SAVE)&&(prev_gs!=GS_SAVE)&&user_valid. load_evt uses the same rule with GS_LOAD.
- States:
  - CLEAR: address_out<=BASE_ADDR+idx, data_out<=0, r_w<=1. When idx==NUM_USERS−1, go to CLR_END; otherwise idx++.
  - CLR_END: r_w<=0, go to IDLE.
  - IDLE: r_w<=0. If save_evt: cur_level<=next, data_out<=next, address_out<=slot addr, r_w<=1, go to SAVE. Else if load_evt: address_out<=slot addr, r_w<=0, go to LD_WAIT.
  - SAVE: r_w<=0, go to IDLE.
  - LD_WAIT: go to LD_CAP.
  - LD_CAP: cur_level<=data_in, go to IDLE.
- next = cur_level+1, computed in LEVEL_W bits.
- save_evt and load_evt cannot both be true in one cycle, because game_state holds a single code.
- Events that occur while busy=1 are dropped; no queuing. prev_gs still advances, so a held state never re-fires.
- An unknown user_id generates no RAM access and leaves cur_level unchanged.
- The slot is latched when the event is taken. A change of user_id mid-load does not affect the address.

## Timing
- Clear sweep: r_w=1 for exactly NUM_USERS consecutive cycles, starting the first clk edge after reset deasserts, with addresses BASE_ADDR..BASE_ADDR+NUM_USERS−1. busy falls NUM_USERS+1 cycles after the first edge.
- Save: the event is sampled at edge E. r_w, address and data are valid for exactly one cycle after E. cur_level updates at E. busy is high for 1 cycle.
- Load: address is valid after edge E, and data_in is sampled at E+2. cur_level updates at E+2. busy is high for 2 cycles.
- Asserting reset mid-operation immediately forces the reset values and aborts any write. The clear sweep restarts on release.

## Configuration
- LEVEL_SATURATE_EN defined: next = (cur_level>=MAX_LEVEL) ? MAX_LEVEL : cur_level+1. The saved value never exceeds MAX_LEVEL.
- LEVEL_SATURATE_EN undefined: next wraps modulo 2^LEVEL_W, and MAX_LEVEL is ignored.

## Test plan
- Reset release with defaults → r_w=1 at addresses 0,1,2,3 with data_out=0 for 4 cycles, then r_w=0, and busy=0 on cycle 5.
- user_id=4'b0011, game_state 8'h00→8'h20 held for 10 cycles → exactly one write pulse at address 1, data_out=1, cur_level=1.
- user_id=4'b1101, game_state→8'h30 with the RAM model returning 8'h07 → address_out=2, r_w=0, and cur_level=8'h07 two cycles after the edge.
- user_id=4'b1111 with GS_SAVE and then GS_LOAD edges → user_valid=0, no r_w pulse, cur_level unchanged.
- cur_level=8'hFF followed by a save edge → with LEVEL_SATURATE_EN, writes 8'hFF; without it, writes 8'h00.
- Save edge, then a load edge on the very next cycle, then reset asserted during LD_WAIT → the load is dropped because busy=1, and reset forces all outputs to their reset values and restarts the 4-cycle clear sweep.
